spi_frame_scheduler: RTL and testbench

- Sequences the byte-wide SPI transmitter so that complete measurement frames go out over the SPI link.
- Arbitrates between two 32-bit result sources: req0 = frequency count, req1 = period/duty count. Round-robin on simultaneous requests.
- Serialises the granted word into a framed byte stream: header, 4 data bytes MSB-first, optional checksum.
- Performs the send/done/ack handshake with the transmitter byte by byte.

---
 rtl/spi_frame_scheduler.sv | 200 ++++++++++++++++++++
 tb/tb_spi_frame_scheduler.sv | 353 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_frame_scheduler.sv
// Round-robin frame scheduler for a byte-wide SPI transmitter: header, 4 data bytes MSB-first,
// optional XOR checksum byte when FRAME_CHECKSUM_EN is defined.
`timescale 1ns/1ps
module spi_frame_scheduler #(
    parameter int unsigned TIMEOUT_CYCLES = 1000000,
    parameter int unsigned GAP_CYCLES     = 16,
    parameter logic [3:0]  HDR_MAGIC      = 4'hA
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req0,
    input  logic [31:0] data0,
    input  logic        req1,
    input  logic [31:0] data1,
    output logic        gnt0,
    output logic        gnt1,
    output logic        spi_send,
    output logic [7:0]  spi_data_out,
    input  logic        spi_send_done,
    output logic        spi_ack,
    output logic        frame_busy,
    output logic        frame_done,
    output logic        timeout_err
);

`ifdef FRAME_CHECKSUM_EN
    localparam logic [2:0] LAST = 3'd5;
`else
    localparam logic [2:0] LAST = 3'd4;
`endif
    localparam int unsigned     GAP_W    = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam logic [19:0]     TMO_LAST = 20'(TIMEOUT_CYCLES - 1);
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_GRANT,
        S_LOAD,
        S_SEND,
        S_ACK,
        S_GAP
    } state_t;

    state_t           r_state;
    state_t           w_next;
    logic             r_sync1;
    logic             r_sync2;
    logic             r_rr_last;
    logic             r_src;
    logic [2:0]       r_idx;
    logic [19:0]      r_tcnt;
    logic [GAP_W-1:0] r_gcnt;
    logic             r_timeout_err;
    logic [7:0]       r_data_out;
    logic [31:0]      r_shift_word;
    logic             w_done_s;
    logic             w_win_src;
    logic             w_tmo;
    logic             w_gap_end;
    logic [7:0]       w_hdr;
    logic [7:0]       w_byte;

    function automatic logic [19:0] sat_inc20(input logic [19:0] v);
        return (v == 20'hFFFFF) ? v : v + 20'd1;
    endfunction

    assign w_done_s  = r_sync2;
    // On a tie the source that did not win last time goes first.
    assign w_win_src = (req0 & req1) ? ~r_rr_last : req1;
    assign w_tmo     = (r_tcnt >= TMO_LAST);
    assign w_gap_end = (r_gcnt == GAP_LAST);
    assign w_hdr     = {HDR_MAGIC, 3'b000, r_src};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state       <= S_IDLE;
            r_sync1       <= 1'b0;
            r_sync2       <= 1'b0;
            r_rr_last     <= 1'b1;
            r_src         <= 1'b0;
            r_idx         <= 3'd0;
            r_tcnt        <= 20'd0;
            r_gcnt        <= '0;
            r_timeout_err <= 1'b0;
            r_data_out    <= 8'h00;
        end else begin
            r_state <= w_next;
            r_sync1 <= spi_send_done;
            r_sync2 <= r_sync1;
            case (r_state)
                S_IDLE: begin
                    if (req0 | req1)
                        r_src <= w_win_src;
                end
                S_GRANT: begin
                    r_rr_last     <= r_src;
                    r_timeout_err <= 1'b0;
                    r_idx         <= 3'd0;
                end
                S_LOAD: begin
                    r_data_out <= w_byte;
                    r_tcnt     <= 20'd0;
                end
                S_SEND, S_ACK: begin
                    r_tcnt <= sat_inc20(r_tcnt);
                    r_gcnt <= '0;
                    if (w_next == S_IDLE)
                        r_timeout_err <= 1'b1;
                end
                S_GAP: begin
                    if (w_gap_end) begin
                        r_gcnt <= '0;
                        if (r_idx != LAST)
                            r_idx <= r_idx + 3'd1;
                    end else begin
                        r_gcnt <= r_gcnt + GAP_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (r_state == S_GRANT)
            r_shift_word <= r_src ? data1 : data0;
        else if ((r_state == S_LOAD) && (r_idx != 3'd0) && (r_idx <= 3'd4))
            r_shift_word <= {r_shift_word[23:0], 8'h00};
    end

`ifdef FRAME_CHECKSUM_EN
    logic [7:0] r_csum;

    always_ff @(posedge clk) begin
        if (r_state == S_GRANT)
            r_csum <= 8'h00;
        else if ((r_state == S_LOAD) && (r_idx != LAST))
            r_csum <= r_csum ^ w_byte;
    end
`endif

    always_comb begin
        w_byte = r_shift_word[31:24];
        if (r_idx == 3'd0)
            w_byte = w_hdr;
`ifdef FRAME_CHECKSUM_EN
        else if (r_idx == 3'd5)
            w_byte = r_csum;
`endif
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (req0 | req1) w_next = S_GRANT;
            S_GRANT: w_next = S_LOAD;
            S_LOAD:  w_next = S_SEND;
            S_SEND: begin
                if (w_done_s)
                    w_next = S_ACK;
                else if (w_tmo)
                    w_next = S_IDLE;
            end
            S_ACK: begin
                if (!w_done_s)
                    w_next = S_GAP;
                else if (w_tmo)
                    w_next = S_IDLE;
            end
            S_GAP: begin
                if (w_gap_end)
                    w_next = (r_idx == LAST) ? S_IDLE : S_LOAD;
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_comb begin
        gnt0       = 1'b0;
        gnt1       = 1'b0;
        spi_send   = 1'b0;
        spi_ack    = 1'b0;
        frame_done = 1'b0;
        case (r_state)
            S_GRANT: begin
                gnt0 = ~r_src;
                gnt1 = r_src;
            end
            S_SEND:  spi_send = 1'b1;
            S_ACK:   spi_ack  = 1'b1;
            S_GAP:   frame_done = w_gap_end && (r_idx == LAST);
            default: ;
        endcase
    end

    assign frame_busy   = (r_state != S_IDLE);
    assign timeout_err  = r_timeout_err;
    assign spi_data_out = r_data_out;

endmodule

// File: tb/tb_spi_frame_scheduler.sv
// Scoreboard bench for spi_frame_scheduler with a behavioural SPI transmitter model.
`timescale 1ns/1ps
module tb_spi_frame_scheduler;
    localparam int TMO = 50;
    localparam int GAP = 5;
`ifdef FRAME_CHECKSUM_EN
    localparam int NB = 6;
`else
    localparam int NB = 5;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        req0, req1;
    logic [31:0] data0, data1;
    logic        gnt0, gnt1;
    logic        spi_send;
    logic [7:0]  spi_data_out;
    logic        spi_send_done;
    logic        spi_ack;
    logic        frame_busy, frame_done, timeout_err;

    spi_frame_scheduler #(
        .TIMEOUT_CYCLES(TMO),
        .GAP_CYCLES    (GAP),
        .HDR_MAGIC     (4'hA)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .req0         (req0),
        .data0        (data0),
        .req1         (req1),
        .data1        (data1),
        .gnt0         (gnt0),
        .gnt1         (gnt1),
        .spi_send     (spi_send),
        .spi_data_out (spi_data_out),
        .spi_send_done(spi_send_done),
        .spi_ack      (spi_ack),
        .frame_busy   (frame_busy),
        .frame_done   (frame_done),
        .timeout_err  (timeout_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          kind;   // 0 complete frame, 1 timeout while sending, 2 timeout while acking
        int          src;
        logic [31:0] word;
    } exp_t;

    exp_t        exp_q[$];
    int          gnt_q[$];
    logic [7:0]  got[$];
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          m_rr = 1;
    int          tx_mode = 0;  // 0 normal, 1 done never rises, 2 done never falls
    logic [31:0] words0[8];
    logic [31:0] words1[8];

    function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endfunction

    function automatic void fail(input string name);
        checks++;
        errors++;
        $display("FAIL %s: got event expected none", name);
    endfunction

    function automatic logic [7:0] exp_byte(input int src, input logic [31:0] w, input int i);
        logic [7:0] b[0:5];
        b[0] = {4'hA, 3'b000, 1'(src)};
        for (int k = 1; k <= 4; k++) b[k] = w[(4-k)*8 +: 8];
        b[5] = b[0] ^ b[1] ^ b[2] ^ b[3] ^ b[4];
        return b[i];
    endfunction

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Transmitter: raises done a random delay after spi_send, drops it a random delay after spi_ack.
    initial begin
        int tx_st;
        int tx_cnt;
        tx_st = 0;
        tx_cnt = 0;
        spi_send_done = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                tx_st = 0;
                spi_send_done = 1'b0;
            end else begin
                case (tx_st)
                    0: if (spi_send) begin tx_cnt = $urandom_range(2, 20); tx_st = 1; end
                    1: begin
                        if (!spi_send) tx_st = 0;
                        else if (tx_mode != 1) begin
                            if (tx_cnt == 0) begin spi_send_done = 1'b1; tx_st = 2; end
                            else tx_cnt--;
                        end
                    end
                    2: begin
                        if (spi_ack) begin
                            tx_cnt = $urandom_range(0, 10);
                            tx_st = (tx_mode == 2) ? 4 : 3;
                        end else if (!spi_send) begin
                            spi_send_done = 1'b0;
                            tx_st = 0;
                        end
                    end
                    3: begin
                        if (tx_cnt == 0) begin spi_send_done = 1'b0; tx_st = 0; end
                        else tx_cnt--;
                    end
                    default: if (!spi_ack) begin spi_send_done = 1'b0; tx_st = 0; end
                endcase
            end
        end
    end

    // Monitor: pops expectations whenever the DUT grants, finishes a frame or times out.
    initial begin
        exp_t e;
        int   g;
        logic in_frame, prev_send, prev_ack, prev_tmo, after_gnt, after_done;
        int   send_cyc;
        in_frame = 0; prev_send = 0; prev_ack = 0; prev_tmo = 0;
        after_gnt = 0; after_done = 0; send_cyc = 0;
        forever begin
            @(negedge clk);
            if (rst) begin
                got.delete();
                in_frame = 0; prev_send = 0; prev_ack = 0; prev_tmo = 0;
                after_gnt = 0; after_done = 0;
            end else begin
                if (after_gnt) begin
                    chk("tmo_clear_on_grant", 64'(timeout_err), 64'(0));
                    chk("busy_after_grant", 64'(frame_busy), 64'(1));
                    after_gnt = 0;
                end
                if (after_done) begin
                    chk("busy_after_done", 64'(frame_busy), 64'(0));
                    after_done = 0;
                end
                if (gnt0 | gnt1) begin
                    chk("gnt_onehot", 64'(gnt0 & gnt1), 64'(0));
                    chk("gnt_during_frame", 64'(in_frame), 64'(0));
                    if (gnt_q.size() == 0) fail("unexpected_gnt");
                    else begin
                        g = gnt_q.pop_front();
                        chk("gnt_src", 64'(gnt1), 64'(g));
                    end
                    in_frame = 1;
                    got.delete();
                    after_gnt = 1;
                end
                if (spi_send && !prev_send) begin
                    got.push_back(spi_data_out);
                    send_cyc = cyc;
                end else if (spi_send && got.size() > 0) begin
                    chk("data_stable", 64'(spi_data_out), 64'(got[$]));
                end
                if (frame_done) begin
                    if (exp_q.size() == 0) fail("unexpected_frame_done");
                    else begin
                        e = exp_q.pop_front();
                        chk("frame_not_timeout", 64'(e.kind), 64'(0));
                        chk("frame_len", 64'(got.size()), 64'(NB));
                        for (int i = 0; i < NB && i < got.size(); i++)
                            chk($sformatf("byte%0d", i), 64'(got[i]), 64'(exp_byte(e.src, e.word, i)));
                    end
                    in_frame = 0;
                    after_done = 1;
                end
                if (timeout_err && !prev_tmo) begin
                    if (exp_q.size() == 0) fail("unexpected_timeout");
                    else begin
                        e = exp_q.pop_front();
                        chk("tmo_expected", 64'(e.kind != 0), 64'(1));
                        chk("tmo_duration", 64'(cyc - send_cyc), 64'(TMO));
                        if (e.kind == 1) chk("tmo_in_send", 64'(prev_send), 64'(1));
                        else             chk("tmo_in_ack", 64'(prev_ack), 64'(1));
                        chk("tmo_send_low", 64'(spi_send), 64'(0));
                        chk("tmo_ack_low", 64'(spi_ack), 64'(0));
                        chk("tmo_busy_low", 64'(frame_busy), 64'(0));
                    end
                    in_frame = 0;
                end
                prev_send = spi_send;
                prev_ack  = spi_ack;
                prev_tmo  = timeout_err;
            end
        end
    end

    task automatic requester(input int src, input int n, input int late);
        bit ok;
        if (n == 0) return;
        repeat (late) @(posedge clk);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            if (src == 0) begin data0 = words0[i]; req0 = 1'b1; end
            else          begin data1 = words1[i]; req1 = 1'b1; end
            ok = 0;
            for (int t = 0; t < 3000 && !ok; t++) begin
                @(negedge clk);
                if ((src == 0) ? gnt0 : gnt1) ok = 1;
            end
            if (!ok) begin
                fail($sformatf("gnt%0d_wait_expired", src));
                break;
            end
        end
        @(posedge clk);
        #1;
        if (src == 0) req0 = 1'b0;
        else          req1 = 1'b0;
    endtask

    task automatic run_round(input int n0, input int n1, input int late1, input int kind,
                             input bit use_fixed, input logic [31:0] fixed_w);
        int   p0, p1, last, pick;
        bit   first;
        exp_t e;
        for (int i = 0; i < 8; i++) begin
            words0[i] = $urandom;
            words1[i] = $urandom;
        end
        if (use_fixed) words0[0] = fixed_w;
        p0 = 0; p1 = 0; last = m_rr; first = 1;
        while (p0 < n0 || p1 < n1) begin
            if (late1 > 0 && first && n0 > 0) pick = 0;
            else if (p0 < n0 && p1 < n1)       pick = (last == 1) ? 0 : 1;
            else                               pick = (p0 < n0) ? 0 : 1;
            first = 0;
            gnt_q.push_back(pick);
            e.kind = kind;
            e.src  = pick;
            e.word = pick ? words1[p1] : words0[p0];
            exp_q.push_back(e);
            if (pick == 1) p1++; else p0++;
            last = pick;
        end
        m_rr = last;
        fork
            requester(0, n0, 0);
            requester(1, n1, late1);
        join
        for (int t = 0; t < 5000 && exp_q.size() > 0; t++) @(negedge clk);
        if (exp_q.size() > 0) begin
            fail("drain_expired");
            exp_q.delete();
            gnt_q.delete();
        end
        repeat (3) @(negedge clk);
    endtask

    initial begin
        exp_t e;
        bit   ok;
        int   n0, n1;
        rst = 1'b1; req0 = 1'b0; req1 = 1'b0; data0 = '0; data1 = '0;
        repeat (3) @(negedge clk);
        #1;
        chk("rst_gnt0", 64'(gnt0), 64'(0));
        chk("rst_gnt1", 64'(gnt1), 64'(0));
        chk("rst_send", 64'(spi_send), 64'(0));
        chk("rst_data", 64'(spi_data_out), 64'(0));
        chk("rst_ack", 64'(spi_ack), 64'(0));
        chk("rst_busy", 64'(frame_busy), 64'(0));
        chk("rst_done", 64'(frame_done), 64'(0));
        chk("rst_tmo", 64'(timeout_err), 64'(0));
        #1 rst = 1'b0;

        run_round(1, 1, 0, 0, 0, 32'h0);
        run_round(1, 0, 0, 0, 1, 32'h12345678);
        run_round(3, 3, 0, 0, 0, 32'h0);
        for (int r = 0; r < 6; r++) begin
            n0 = $urandom_range(0, 2);
            n1 = $urandom_range(0, 2);
            if (n0 == 0 && n1 == 0) n0 = 1;
            run_round(n0, n1, 0, 0, 0, 32'h0);
        end
        run_round(1, 1, 20, 0, 0, 32'h0);

        tx_mode = 1;
        run_round(1, 0, 0, 1, 0, 32'h0);
        tx_mode = 0;
        chk("tmo_sticky", 64'(timeout_err), 64'(1));
        run_round(0, 1, 0, 0, 0, 32'h0);

        tx_mode = 2;
        run_round(0, 1, 0, 2, 0, 32'h0);
        tx_mode = 0;
        repeat (5) @(negedge clk);
        run_round(1, 0, 0, 0, 0, 32'h0);

        gnt_q.push_back(0);
        e.kind = 0; e.src = 0; e.word = 32'h0;
        exp_q.push_back(e);
        @(posedge clk);
        #1 data0 = $urandom; req0 = 1'b1;
        ok = 0;
        for (int t = 0; t < 3000 && !ok; t++) begin
            @(negedge clk);
            if (gnt0) ok = 1;
        end
        if (!ok) fail("rst_test_gnt_expired");
        @(posedge clk);
        #1 req0 = 1'b0;
        ok = 0;
        for (int t = 0; t < 3000 && !ok; t++) begin
            @(negedge clk);
            #1;
            if (got.size() == 3 && spi_send) ok = 1;
        end
        if (!ok) fail("rst_test_byte2_expired");
        #1 rst = 1'b1;
        #1;
        chk("midrst_send", 64'(spi_send), 64'(0));
        chk("midrst_ack", 64'(spi_ack), 64'(0));
        chk("midrst_busy", 64'(frame_busy), 64'(0));
        chk("midrst_data", 64'(spi_data_out), 64'(0));
        exp_q.delete();
        gnt_q.delete();
        m_rr = 1;
        repeat (3) @(negedge clk);
        #2 rst = 1'b0;
        run_round(1, 0, 0, 0, 0, 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "watchdog");
    end

endmodule
